// File: rtl/vpu_pkg.sv
// ============================================================================
// Package  : vpu_pkg
// Brief    : Shared video-pipeline constants, FSM encoding and helpers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vpu_pkg;

    localparam int c_h_max       = 640;
    localparam int c_v_max       = 480;
    localparam int c_scale_log2  = 2;
    localparam int c_color_w     = 9;
    localparam int c_addr_w      = 15;
    localparam int c_buf_depth   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } bg_state_t;

    // Constant multiply built from shifted partial sums of the set bits of k.
    function automatic logic [c_addr_w-1:0] mul_const(
        input logic [c_addr_w-1:0] a,
        input int unsigned         k
    );
        logic [c_addr_w-1:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            if (k[i]) begin
                acc = acc + (a << i);
            end
        end
        return acc;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bg_skid_buffer.sv
// ============================================================================
// Module   : bg_skid_buffer
// Brief    : Four-entry FIFO holding returned background samples until the
//            downstream FIFO accepts them. Overflow is prevented upstream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bg_skid_buffer
    import vpu_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] r_mem [0:c_buf_depth-1];
    logic [1:0]       r_wr_ptr;
    logic [1:0]       r_rd_ptr;
    logic [2:0]       r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
            for (int i = 0; i < c_buf_depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clear) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign empty     = (r_count == 3'd0);
    assign head_data = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/bg_fifo_writer.sv
// ============================================================================
// Module   : bg_fifo_writer
// Brief    : Walks the frame in raster order, reads the scaled background
//            memory and streams samples into the background FIFO, using a
//            credit scheme so in-flight plus buffered samples never exceed 4.
// Options  : BG_SCROLL_EN adds scroll_col / scroll_row frame offsets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bg_fifo_writer
    import vpu_pkg::*;
#(
    parameter int H_MAX      = c_h_max,
    parameter int V_MAX      = c_v_max,
    parameter int SCALE_LOG2 = c_scale_log2,
    parameter int COLOR_W    = c_color_w
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               frame_sync,
    output logic [14:0]        mem_addr,
    input  logic [COLOR_W-1:0] mem_rddata,
    input  logic               bg_fifo_full,
    output logic               bg_fifo_wrreq,
    output logic [COLOR_W-1:0] bg_fifo_data,
    output logic               frame_done
`ifdef BG_SCROLL_EN
    ,
    input  logic [7:0]         scroll_col,
    input  logic [6:0]         scroll_row
`endif
);

    localparam int c_x_w = $clog2(H_MAX);
    localparam int c_y_w = $clog2(V_MAX);
    localparam logic [c_x_w-1:0] c_x_last = c_x_w'(H_MAX - 1);
    localparam logic [c_y_w-1:0] c_y_last = c_y_w'(V_MAX - 1);

    bg_state_t r_state;
    bg_state_t w_state_next;

    logic [c_x_w-1:0]    r_x;
    logic [c_y_w-1:0]    r_y;
    logic [c_addr_w-1:0] r_mem_addr;
    logic [2:0]          r_vld;
    logic [2:0]          r_last;
    logic [2:0]          r_credits;

    logic                w_issue;
    logic                w_pop;
    logic                w_last_px;
    logic                w_buf_empty;
    logic [COLOR_W:0]    w_buf_head;
    logic [c_addr_w-1:0] w_col;
    logic [c_addr_w-1:0] w_row;
    logic [c_addr_w-1:0] w_addr_next;

`ifdef BG_SCROLL_EN
    localparam logic [c_addr_w-1:0] c_cols_a = c_addr_w'(H_MAX >> SCALE_LOG2);
    localparam logic [c_addr_w-1:0] c_rows_a = c_addr_w'(V_MAX >> SCALE_LOG2);

    logic [7:0]          r_scroll_col;
    logic [6:0]          r_scroll_row;
    logic [c_addr_w-1:0] w_col_sum;
    logic [c_addr_w-1:0] w_row_sum;

    // Offsets are latched only between frames so a frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scroll_col <= 8'd0;
            r_scroll_row <= 7'd0;
        end else if ((r_state != ST_RUN) || (w_issue && w_last_px)) begin
            r_scroll_col <= scroll_col;
            r_scroll_row <= scroll_row;
        end
    end

    // Offsets are expected within one wrap of the block grid.
    assign w_col_sum = c_addr_w'(r_x >> SCALE_LOG2) + c_addr_w'(r_scroll_col);
    assign w_row_sum = c_addr_w'(r_y >> SCALE_LOG2) + c_addr_w'(r_scroll_row);
    assign w_col     = (w_col_sum >= c_cols_a) ? (w_col_sum - c_cols_a) : w_col_sum;
    assign w_row     = (w_row_sum >= c_rows_a) ? (w_row_sum - c_rows_a) : w_row_sum;
`else
    assign w_col = c_addr_w'(r_x >> SCALE_LOG2);
    assign w_row = c_addr_w'(r_y >> SCALE_LOG2);
`endif

    assign w_addr_next = mul_const(w_row, H_MAX >> SCALE_LOG2) + w_col;
    assign w_last_px   = (r_x == c_x_last) && (r_y == c_y_last);

    // A pop this cycle frees a credit in time for a same-cycle issue.
    assign w_pop   = !w_buf_empty && !bg_fifo_full && !frame_sync;
    assign w_issue = (r_state == ST_RUN) && enable && !frame_sync &&
                     ((r_credits < 3'd4) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (frame_sync) begin
                    w_state_next = ST_FLUSH;
                end else if (enable) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (frame_sync) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!frame_sync && (r_vld == 3'd0)) begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // r_vld/r_last track each read through the two-cycle memory latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x        <= '0;
            r_y        <= '0;
            r_mem_addr <= '0;
            r_vld      <= 3'd0;
            r_last     <= 3'd0;
            r_credits  <= 3'd0;
        end else if (frame_sync) begin
            r_x       <= '0;
            r_y       <= '0;
            r_vld     <= 3'd0;
            r_last    <= 3'd0;
            r_credits <= 3'd0;
        end else begin
            r_vld  <= {r_vld[1:0], w_issue};
            r_last <= {r_last[1:0], w_issue && w_last_px};
            if (w_issue) begin
                r_mem_addr <= w_addr_next;
                if (r_x == c_x_last) begin
                    r_x <= '0;
                    r_y <= (r_y == c_y_last) ? '0 : r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
            case ({w_issue, w_pop})
                2'b10:   r_credits <= r_credits + 3'd1;
                2'b01:   r_credits <= r_credits - 3'd1;
                default: r_credits <= r_credits;
            endcase
        end
    end

    bg_skid_buffer #(
        .WIDTH (COLOR_W + 1)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (frame_sync),
        .push      (r_vld[2]),
        .push_data ({r_last[2], mem_rddata}),
        .pop       (w_pop),
        .empty     (w_buf_empty),
        .head_data (w_buf_head)
    );

    assign mem_addr      = r_mem_addr;
    assign bg_fifo_wrreq = w_pop;
    assign bg_fifo_data  = w_buf_head[COLOR_W-1:0];
    assign frame_done    = w_pop && w_buf_head[COLOR_W];

endmodule

`default_nettype wire
